// File: rtl/ext_mailbox.sv
// ext_mailbox: register-bus mailbox with a TX FIFO drained by an outbound
// valid/ready stream and an RX FIFO filled by an inbound valid/ready stream.
// Register map: 0x00 TXDATA (W), 0x04 RXDATA (R, pops), 0x08 STATUS (R), 0x0C CTRL (RW).
// Optional feature macro: EXT_MAILBOX_IRQ_EN adds the CTRL[1:0] interrupt enables
// and drives irq_o; without it irq_o is tied low and CTRL[1:0] reads 0.
module ext_mailbox #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        reg_valid_i,
    input  logic        reg_write_i,
    input  logic [31:0] reg_addr_i,
    input  logic [31:0] reg_wdata_i,
    input  logic [3:0]  reg_wstrb_i,
    output logic        reg_ready_o,
    output logic [31:0] reg_rdata_o,
    output logic        reg_error_o,
    output logic        tx_valid_o,
    output logic [31:0] tx_data_o,
    input  logic        tx_ready_i,
    input  logic        rx_valid_i,
    input  logic [31:0] rx_data_i,
    output logic        rx_ready_o,
    output logic        irq_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CntFull = CW'(DEPTH);

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    state_e        state_q;
    logic          ready_q;
    logic [31:0]   rdata_q;
    logic          error_q;

    logic [31:0]   tx_mem [DEPTH];
    logic [31:0]   rx_mem [DEPTH];
    logic [AW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
    logic [CW-1:0] tx_cnt_q, rx_cnt_q;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic acc;
    logic err_d;
    logic [31:0] rdata_d;
    logic [31:0] status;
    logic [31:0] ctrl_rd;
    logic tx_bus_push, rx_bus_pop, ctrl_wr;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic flush_tx, flush_rx;
    logic unused_addr;

    assign unused_addr = ^reg_addr_i[31:5];

    assign tx_full  = (tx_cnt_q == CntFull);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CntFull);
    assign rx_empty = (rx_cnt_q == '0);

    assign tx_valid_o  = !tx_empty;
    assign tx_data_o   = tx_empty ? 32'h0 : tx_mem[tx_rd_q];
    assign rx_ready_o  = !rx_full;
    assign reg_ready_o = ready_q;
    assign reg_rdata_o = rdata_q;
    assign reg_error_o = error_q;

`ifdef EXT_MAILBOX_IRQ_EN
    logic rx_irq_en_q, tx_irq_en_q;
    assign ctrl_rd = {30'h0, tx_irq_en_q, rx_irq_en_q};
    assign irq_o   = (rx_irq_en_q & !rx_empty) | (tx_irq_en_q & tx_empty);
`else
    assign ctrl_rd = 32'h0;
    assign irq_o   = 1'b0;
`endif

    // Decode the presented request against pre-edge FIFO state.
    always_comb begin
        acc         = (state_q == StIdle) && reg_valid_i;
        err_d       = 1'b0;
        rdata_d     = 32'h0;
        tx_bus_push = 1'b0;
        rx_bus_pop  = 1'b0;
        ctrl_wr     = 1'b0;
        status      = 32'h0;
        status[0]     = tx_full;
        status[1]     = tx_empty;
        status[2]     = rx_full;
        status[3]     = rx_empty;
        status[15:8]  = 8'(tx_cnt_q);
        status[23:16] = 8'(rx_cnt_q);
        if (reg_addr_i[4] || (reg_addr_i[1:0] != 2'b00)) begin
            err_d = 1'b1;
        end else if (reg_write_i) begin
            if (reg_wstrb_i != 4'hF) begin
                err_d = 1'b1;
            end else begin
                case (reg_addr_i[3:2])
                    2'd0: begin
                        if (tx_full) err_d = 1'b1;
                        else         tx_bus_push = 1'b1;
                    end
                    2'd3:    ctrl_wr = 1'b1;
                    default: err_d = 1'b1;
                endcase
            end
        end else begin
            case (reg_addr_i[3:2])
                2'd1: begin
                    if (rx_empty) begin
                        err_d = 1'b1;
                    end else begin
                        rx_bus_pop = 1'b1;
                        rdata_d    = rx_mem[rx_rd_q];
                    end
                end
                2'd2:    rdata_d = status;
                2'd3:    rdata_d = ctrl_rd;
                default: err_d = 1'b1;
            endcase
        end
        tx_push  = acc && tx_bus_push;
        rx_pop   = acc && rx_bus_pop;
        flush_tx = acc && ctrl_wr && reg_wdata_i[8];
        flush_rx = acc && ctrl_wr && reg_wdata_i[9];
        tx_pop   = tx_valid_o && tx_ready_i;
        rx_push  = rx_valid_i && rx_ready_o;
    end

    // Bus FSM with registered response; the response lasts exactly one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
            rdata_q <= 32'h0;
            error_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (reg_valid_i) begin
                        state_q <= StResp;
                        ready_q <= 1'b1;
                        rdata_q <= rdata_d;
                        error_q <= err_d;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    ready_q <= 1'b0;
                    rdata_q <= 32'h0;
                    error_q <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // FIFO pointers, counts and interrupt enables; flush overrides push/pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
`ifdef EXT_MAILBOX_IRQ_EN
            rx_irq_en_q <= 1'b0;
            tx_irq_en_q <= 1'b0;
`endif
        end else begin
            if (flush_tx) begin
                tx_wr_q  <= '0;
                tx_rd_q  <= '0;
                tx_cnt_q <= '0;
            end else begin
                if (tx_push) tx_wr_q <= tx_wr_q + AW'(1);
                if (tx_pop)  tx_rd_q <= tx_rd_q + AW'(1);
                if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + CW'(1);
                else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - CW'(1);
            end
            if (flush_rx) begin
                rx_wr_q  <= '0;
                rx_rd_q  <= '0;
                rx_cnt_q <= '0;
            end else begin
                if (rx_push) rx_wr_q <= rx_wr_q + AW'(1);
                if (rx_pop)  rx_rd_q <= rx_rd_q + AW'(1);
                if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + CW'(1);
                else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - CW'(1);
            end
`ifdef EXT_MAILBOX_IRQ_EN
            if (acc && ctrl_wr) begin
                rx_irq_en_q <= reg_wdata_i[0];
                tx_irq_en_q <= reg_wdata_i[1];
            end
`endif
        end
    end

    // Storage arrays are not reset; pointers keep stale entries unobservable.
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wr_q] <= reg_wdata_i;
        if (rx_push) rx_mem[rx_wr_q] <= rx_data_i;
    end

endmodule

// File: tb/tb_ext_mailbox.sv
// Self-checking bench for ext_mailbox (DEPTH=8). Expected bus responses and
// stream words are queued when stimulus is driven and compared on output.
module tb_ext_mailbox;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        reg_valid_i = 1'b0;
    logic        reg_write_i = 1'b0;
    logic [31:0] reg_addr_i = 32'h0;
    logic [31:0] reg_wdata_i = 32'h0;
    logic [3:0]  reg_wstrb_i = 4'h0;
    logic        reg_ready_o;
    logic [31:0] reg_rdata_o;
    logic        reg_error_o;
    logic        tx_valid_o;
    logic [31:0] tx_data_o;
    logic        tx_ready_i = 1'b0;
    logic        rx_valid_i = 1'b0;
    logic [31:0] rx_data_i = 32'h0;
    logic        rx_ready_o;
    logic        irq_o;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [32:0] bus_exp_q [$];
    logic [31:0] tx_exp_q  [$];
    logic [31:0] rx_exp_q  [$];

    ext_mailbox #(.DEPTH(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .reg_valid_i (reg_valid_i),
        .reg_write_i (reg_write_i),
        .reg_addr_i  (reg_addr_i),
        .reg_wdata_i (reg_wdata_i),
        .reg_wstrb_i (reg_wstrb_i),
        .reg_ready_o (reg_ready_o),
        .reg_rdata_o (reg_rdata_o),
        .reg_error_o (reg_error_o),
        .tx_valid_o  (tx_valid_o),
        .tx_data_o   (tx_data_o),
        .tx_ready_i  (tx_ready_i),
        .rx_valid_i  (rx_valid_i),
        .rx_data_i   (rx_data_i),
        .rx_ready_o  (rx_ready_o),
        .irq_o       (irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Bus driver: returns response and cycles from request to reg_ready_o.
    task automatic bus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output logic [31:0] rd, output logic er,
                       output int lat);
        reg_valid_i = 1'b1;
        reg_write_i = wr;
        reg_addr_i  = addr;
        reg_wdata_i = wdata;
        reg_wstrb_i = strb;
        lat = 0;
        do begin
            @(posedge clk_i); #1;
            lat++;
        end while (!reg_ready_o && lat < 8);
        rd = reg_rdata_o;
        er = reg_error_o;
        reg_valid_i = 1'b0;
        reg_write_i = 1'b0;
        reg_addr_i  = 32'h0;
        reg_wdata_i = 32'h0;
        reg_wstrb_i = 4'h0;
        @(posedge clk_i); #1;
    endtask

    // Inbound stream driver: one word, bounded wait for rx_ready_o.
    task automatic rx_push(input logic [31:0] d);
        int n = 0;
        rx_valid_i = 1'b1;
        rx_data_i  = d;
        while (!rx_ready_o && n < 16) begin
            @(posedge clk_i); #1;
            n++;
        end
        @(posedge clk_i); #1;
        rx_valid_i = 1'b0;
        rx_data_i  = 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er; int lat; logic [32:0] e;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk_cnt++;
        if ({reg_ready_o, reg_rdata_o, reg_error_o, tx_valid_o, tx_data_o, rx_ready_o, irq_o}
            !== {1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0}) begin
            $display("FAIL reset_outputs: ready=%b rdata=%h err=%b txv=%b txd=%h rxr=%b irq=%b",
                     reg_ready_o, reg_rdata_o, reg_error_o, tx_valid_o, tx_data_o, rx_ready_o,
                     irq_o);
        end else pass_cnt++;
        bus_exp_q.push_back({1'b0, 32'h0000_000A});
        bus(1'b0, 32'h08, 32'h0, 4'h0, rd, er, lat);
        e = bus_exp_q.pop_front();
        chk_cnt++;
        if ({er, rd} !== e || lat != 1) begin
            $display("FAIL reset_status: got err=%b rdata=%h lat=%0d want %h lat=1",
                     er, rd, lat, e);
        end else pass_cnt++;
        chk_cnt++;
        if (reg_ready_o !== 1'b0 || reg_rdata_o !== 32'h0 || reg_error_o !== 1'b0) begin
            $display("FAIL ready_one_cycle: ready=%b rdata=%h err=%b want 0",
                     reg_ready_o, reg_rdata_o, reg_error_o);
        end else pass_cnt++;
    endtask

    task automatic test_tx_fill();
        logic [31:0] rd; logic er; int lat; logic [32:0] e; logic [31:0] t;
        tx_ready_i = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            bus_exp_q.push_back({(i == 9), 32'h0});
            if (i <= 8) tx_exp_q.push_back(32'(i));
            bus(1'b1, 32'h00, 32'(i), 4'hF, rd, er, lat);
            e = bus_exp_q.pop_front();
            chk_cnt++;
            if ({er, rd} !== e || lat != 1) begin
                $display("FAIL tx_write_%0d: got err=%b rdata=%h lat=%0d want %h",
                         i, er, rd, lat, e);
            end else pass_cnt++;
        end
        bus_exp_q.push_back({1'b0, 32'h0000_0809});
        bus(1'b0, 32'h08, 32'h0, 4'h0, rd, er, lat);
        e = bus_exp_q.pop_front();
        chk_cnt++;
        if ({er, rd} !== e || lat != 1) begin
            $display("FAIL tx_full_status: got err=%b rdata=%h want %h", er, rd, e);
        end else pass_cnt++;
        tx_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            t = tx_exp_q.pop_front();
            chk_cnt++;
            if (tx_valid_o !== 1'b1 || tx_data_o !== t) begin
                $display("FAIL tx_stream_%0d: valid=%b data=%h want valid=1 data=%h",
                         i, tx_valid_o, tx_data_o, t);
            end else pass_cnt++;
            @(posedge clk_i); #1;
        end
        tx_ready_i = 1'b0;
        chk_cnt++;
        if (tx_valid_o !== 1'b0 || tx_data_o !== 32'h0) begin
            $display("FAIL tx_drained: valid=%b data=%h want 0", tx_valid_o, tx_data_o);
        end else pass_cnt++;
    endtask

    task automatic test_rx_basic();
        logic [31:0] rd; logic er; int lat; logic [32:0] e;
        bus_exp_q.push_back({1'b1, 32'h0});
        bus(1'b0, 32'h04, 32'h0, 4'h0, rd, er, lat);
        e = bus_exp_q.pop_front();
        chk_cnt++;
        if ({er, rd} !== e || lat != 1) begin
            $display("FAIL rx_empty_read: got err=%b rdata=%h want %h", er, rd, e);
        end else pass_cnt++;
        rx_push(32'hDEAD_BEEF);
        bus_exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        bus_exp_q.push_back({1'b0, 32'h0000_000A});
        bus(1'b0, 32'h04, 32'h0, 4'h0, rd, er, lat);
        e = bus_exp_q.pop_front();
        chk_cnt++;
        if ({er, rd} !== e || lat != 1) begin
            $display("FAIL rx_read: got err=%b rdata=%h want %h", er, rd, e);
        end else pass_cnt++;
        bus(1'b0, 32'h08, 32'h0, 4'h0, rd, er, lat);
        e = bus_exp_q.pop_front();
        chk_cnt++;
        if ({er, rd} !== e || lat != 1) begin
            $display("FAIL rx_read_status: got err=%b rdata=%h want %h", er, rd, e);
        end else pass_cnt++;
    endtask

    task automatic test_rx_full();
        logic [31:0] rd; logic er; int lat; logic [32:0] e; logic [31:0] t;
        for (int i = 0; i < 8; i++) begin
            rx_exp_q.push_back(32'h100 + 32'(i));
            rx_push(32'h100 + 32'(i));
        end
        bus_exp_q.push_back({1'b0, 32'h0008_0006});
        bus(1'b0, 32'h08, 32'h0, 4'h0, rd, er, lat);
        e = bus_exp_q.pop_front();
        chk_cnt++;
        if ({er, rd} !== e || lat != 1 || rx_ready_o !== 1'b0) begin
            $display("FAIL rx_full_status: got err=%b rdata=%h rxr=%b want %h rxr=0",
                     er, rd, rx_ready_o, e);
        end else pass_cnt++;
        // Pop and offer a word in the same cycle: the offer must be refused.
        reg_valid_i = 1'b1;
        reg_write_i = 1'b0;
        reg_addr_i  = 32'h04;
        rx_valid_i  = 1'b1;
        rx_data_i   = 32'h0000_BAD0;
        @(posedge clk_i); #1;
        rx_valid_i  = 1'b0;
        t = rx_exp_q.pop_front();
        chk_cnt++;
        if (reg_ready_o !== 1'b1 || reg_error_o !== 1'b0 || reg_rdata_o !== t ||
            rx_ready_o !== 1'b1) begin
            $display("FAIL rx_pop_while_full: ready=%b err=%b rdata=%h rxr=%b want 1 0 %h 1",
                     reg_ready_o, reg_error_o, reg_rdata_o, rx_ready_o, t);
        end else pass_cnt++;
        reg_valid_i = 1'b0;
        reg_addr_i  = 32'h0;
        @(posedge clk_i); #1;
        bus_exp_q.push_back({1'b0, 32'h0007_0002});
        bus(1'b0, 32'h08, 32'h0, 4'h0, rd, er, lat);
        e = bus_exp_q.pop_front();
        chk_cnt++;
        if ({er, rd} !== e || lat != 1) begin
            $display("FAIL rx_count7: got err=%b rdata=%h want %h", er, rd, e);
        end else pass_cnt++;
        rx_exp_q.push_back(32'h200);
        rx_push(32'h200);
        for (int i = 0; i < 8; i++) begin
            t = rx_exp_q.pop_front();
            bus(1'b0, 32'h04, 32'h0, 4'h0, rd, er, lat);
            chk_cnt++;
            if (er !== 1'b0 || rd !== t || lat != 1) begin
                $display("FAIL rx_drain_%0d: got err=%b rdata=%h want err=0 rdata=%h",
                         i, er, rd, t);
            end else pass_cnt++;
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat; logic [32:0] e;
        logic        wr_t   [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] addr_t [7] = '{32'h10, 32'h02, 32'h00, 32'h04, 32'h08, 32'h00, 32'h0E};
        logic [3:0]  strb_t [7] = '{4'hF, 4'hF, 4'h3, 4'hF, 4'hF, 4'hF, 4'hF};
        for (int i = 0; i < 7; i++) begin
            bus_exp_q.push_back({1'b1, 32'h0});
            bus(wr_t[i], addr_t[i], 32'h0000_0305, strb_t[i], rd, er, lat);
            e = bus_exp_q.pop_front();
            chk_cnt++;
            if ({er, rd} !== e || lat != 1) begin
                $display("FAIL err_access_%0d: got err=%b rdata=%h want %h", i, er, rd, e);
            end else pass_cnt++;
        end
        bus_exp_q.push_back({1'b0, 32'h0000_000A});
        bus(1'b0, 32'h08, 32'h0, 4'h0, rd, er, lat);
        e = bus_exp_q.pop_front();
        chk_cnt++;
        if ({er, rd} !== e || tx_valid_o !== 1'b0) begin
            $display("FAIL err_status: got err=%b rdata=%h txv=%b want %h txv=0",
                     er, rd, tx_valid_o, e);
        end else pass_cnt++;
    endtask

    task automatic test_flush();
        logic [31:0] rd; logic er; int lat; logic [32:0] e;
        logic        wr_t   [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                                     1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] addr_t [10] = '{32'h00, 32'h00, 32'h00, 32'h08, 32'h0C, 32'h08,
                                     32'h08, 32'h0C, 32'h08, 32'h0C};
        logic [31:0] wd_t   [10] = '{32'hA1, 32'hA2, 32'hA3, 32'h0, 32'h100, 32'h0,
                                     32'h0, 32'h200, 32'h0, 32'h0};
        logic [31:0] exp_t  [10] = '{32'h0, 32'h0, 32'h0, 32'h0000_0308, 32'h0, 32'h0000_000A,
                                     32'h0002_0002, 32'h0, 32'h0000_000A, 32'h0};
        tx_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 6) begin
                rx_push(32'h31);
                rx_push(32'h32);
            end
            bus_exp_q.push_back({1'b0, exp_t[i]});
            bus(wr_t[i], addr_t[i], wd_t[i], 4'hF, rd, er, lat);
            e = bus_exp_q.pop_front();
            chk_cnt++;
            if ({er, rd} !== e || lat != 1) begin
                $display("FAIL flush_step_%0d: got err=%b rdata=%h want %h", i, er, rd, e);
            end else pass_cnt++;
        end
        chk_cnt++;
        if (tx_valid_o !== 1'b0 || tx_data_o !== 32'h0 || rx_ready_o !== 1'b1) begin
            $display("FAIL flush_outputs: txv=%b txd=%h rxr=%b want 0 0 1",
                     tx_valid_o, tx_data_o, rx_ready_o);
        end else pass_cnt++;
    endtask

    task automatic test_irq();
        logic [31:0] rd; logic er; int lat; logic [32:0] e;
`ifdef EXT_MAILBOX_IRQ_EN
        bus(1'b1, 32'h0C, 32'h1, 4'hF, rd, er, lat);
        chk_cnt++;
        if (er !== 1'b0 || irq_o !== 1'b0) begin
            $display("FAIL irq_en_rx_idle: err=%b irq=%b want 0 0", er, irq_o);
        end else pass_cnt++;
        rx_push(32'h55);
        chk_cnt++;
        if (irq_o !== 1'b1) $display("FAIL irq_rx_set: irq=%b want 1", irq_o);
        else pass_cnt++;
        bus_exp_q.push_back({1'b0, 32'h1});
        bus(1'b0, 32'h0C, 32'h0, 4'h0, rd, er, lat);
        e = bus_exp_q.pop_front();
        chk_cnt++;
        if ({er, rd} !== e) $display("FAIL irq_ctrl_read: got %b %h want %h", er, rd, e);
        else pass_cnt++;
        bus(1'b0, 32'h04, 32'h0, 4'h0, rd, er, lat);
        chk_cnt++;
        if (rd !== 32'h55 || irq_o !== 1'b0) begin
            $display("FAIL irq_rx_clear: rdata=%h irq=%b want 55 0", rd, irq_o);
        end else pass_cnt++;
        bus(1'b1, 32'h0C, 32'h2, 4'hF, rd, er, lat);
        chk_cnt++;
        if (irq_o !== 1'b1) $display("FAIL irq_tx_empty: irq=%b want 1", irq_o);
        else pass_cnt++;
        bus(1'b1, 32'h0C, 32'h100, 4'hF, rd, er, lat);
        chk_cnt++;
        if (irq_o !== 1'b0) $display("FAIL irq_disabled: irq=%b want 0", irq_o);
        else pass_cnt++;
`else
        bus(1'b1, 32'h0C, 32'h3, 4'hF, rd, er, lat);
        chk_cnt++;
        if (er !== 1'b0) $display("FAIL ctrl_wr_noirq: err=%b want 0", er);
        else pass_cnt++;
        bus_exp_q.push_back({1'b0, 32'h0});
        bus(1'b0, 32'h0C, 32'h0, 4'h0, rd, er, lat);
        e = bus_exp_q.pop_front();
        chk_cnt++;
        if ({er, rd} !== e) $display("FAIL ctrl_rd_noirq: got %b %h want %h", er, rd, e);
        else pass_cnt++;
        rx_push(32'h55);
        chk_cnt++;
        if (irq_o !== 1'b0) $display("FAIL irq_tied: irq=%b want 0", irq_o);
        else pass_cnt++;
        bus(1'b0, 32'h04, 32'h0, 4'h0, rd, er, lat);
        chk_cnt++;
        if (rd !== 32'h55 || er !== 1'b0) begin
            $display("FAIL noirq_rx_read: rdata=%h err=%b want 55 0", rd, er);
        end else pass_cnt++;
`endif
    endtask

    task automatic test_reset_in_resp();
        logic [31:0] rd; logic er; int lat; logic [32:0] e;
        tx_ready_i  = 1'b0;
        reg_valid_i = 1'b1;
        reg_write_i = 1'b1;
        reg_addr_i  = 32'h00;
        reg_wdata_i = 32'h77;
        reg_wstrb_i = 4'hF;
        @(posedge clk_i); #1;
        rst_i       = 1'b1;
        reg_valid_i = 1'b0;
        reg_write_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk_cnt++;
        if (reg_ready_o !== 1'b0 || tx_valid_o !== 1'b0 || rx_ready_o !== 1'b1) begin
            $display("FAIL reset_in_resp: ready=%b txv=%b rxr=%b want 0 0 1",
                     reg_ready_o, tx_valid_o, rx_ready_o);
        end else pass_cnt++;
        bus_exp_q.push_back({1'b0, 32'h0000_000A});
        bus(1'b0, 32'h08, 32'h0, 4'h0, rd, er, lat);
        e = bus_exp_q.pop_front();
        chk_cnt++;
        if ({er, rd} !== e || lat != 1) begin
            $display("FAIL reset_in_resp_status: got err=%b rdata=%h want %h", er, rd, e);
        end else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_tx_fill();
        test_rx_basic();
        test_rx_full();
        test_errors();
        test_flush();
        test_irq();
        test_reset_in_resp();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
